// File: rtl/d_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings, word width
// and the address legality check used by the responder.
package d_mem_responder_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // A byte address is illegal if it is not word aligned or if it points past
    // the last word of a 2**depth_log2-word array (no wrap-around).
    function automatic logic addr_err(input logic [WORD_W-1:0] adr, input int depth_log2);
        return (adr[1:0] != 2'b00) || ((adr >> (depth_log2 + 2)) != '0);
    endfunction

endpackage

// File: rtl/d_mem_array.sv
// Word-addressed storage: synchronous write, registered read, no reset.
module d_mem_array
    import d_mem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [WORD_W-1:0]     wdata,
    output logic [WORD_W-1:0]     rdata
);

    logic [WORD_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/d_mem_responder.sv
// MEM-stage load/store slave: captures one request, waits WAIT_CYCLES, then
// answers with a one-cycle ack plus read data and an error flag.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | ready; req sampled, request captured on the accepting edge
// ST_WAIT | counting down wait states; inputs ignored
// ST_RESP | ack (and err) high for this one cycle; back to idle next edge
module d_mem_responder
    import d_mem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              WrEn,
    input  logic [WORD_W-1:0] adr,
    input  logic [WORD_W-1:0] data_in,
    output logic [WORD_W-1:0] data_out,
    output logic              ack,
    output logic              err,
    output logic              busy
);

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic       NO_WAIT  = (WAIT_CYCLES == 0);

    state_t            state;
    logic [3:0]        cnt;
    logic              cap_wr;
    logic [WORD_W-1:0] cap_adr;
    logic [WORD_W-1:0] cap_data;
    logic              rd_valid;
    logic [WORD_W-1:0] rdata;

    logic              acc_wr;
    logic [WORD_W-1:0] acc_adr;
    logic [WORD_W-1:0] acc_data;
    logic              acc_err;
    logic              enter_resp;
    logic              arr_we;
    logic              arr_re;

    // With zero wait states the access happens on the capture edge itself,
    // so the live inputs are used instead of the capture registers.
    always_comb begin
        acc_wr     = cap_wr;
        acc_adr    = cap_adr;
        acc_data   = cap_data;
        enter_resp = 1'b0;
        if (state == ST_IDLE) begin
            acc_wr   = WrEn;
            acc_adr  = adr;
            acc_data = data_in;
            enter_resp = req && NO_WAIT;
        end else if (state == ST_WAIT) begin
            enter_resp = (cnt == 4'd0);
        end
        acc_err = addr_err(acc_adr, DEPTH_LOG2);
        arr_we  = rst_n && enter_resp && acc_wr && !acc_err;
        arr_re  = rst_n && enter_resp && !acc_wr && !acc_err;
    end

    d_mem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .re   (arr_re),
        .idx  (acc_adr[DEPTH_LOG2+1:2]),
        .wdata(acc_data),
        .rdata(rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            cap_wr   <= 1'b0;
            cap_adr  <= '0;
            cap_data <= '0;
            ack      <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        cap_wr   <= WrEn;
                        cap_adr  <= adr;
                        cap_data <= data_in;
                        busy     <= 1'b1;
                        if (NO_WAIT) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
            // rd_valid selects the array read register onto data_out; stores
            // leave it alone so the previous load data is held.
            if (enter_resp) begin
                ack <= 1'b1;
                err <= acc_err;
                if (acc_err) begin
                    rd_valid <= 1'b0;
                end else if (!acc_wr) begin
                    rd_valid <= 1'b1;
                end
            end
        end
    end

    assign data_out = rd_valid ? rdata : '0;

endmodule

// File: tb/tb_d_mem_responder.sv
// Self-checking bench: two responders (2 wait states / 1K words and
// 0 wait states / 4K words) against a word-array reference model.
module tb_d_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_a, wr_a, ack_a, err_a, busy_a;
    logic [31:0] adr_a, din_a, dout_a;
    logic        req_b, wr_b, ack_b, err_b, busy_b;
    logic [31:0] adr_b, din_b, dout_b;

    d_mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) u_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .WrEn(wr_a), .adr(adr_a),
        .data_in(din_a), .data_out(dout_a), .ack(ack_a), .err(err_a), .busy(busy_a)
    );

    d_mem_responder #(.DEPTH_LOG2(12), .WAIT_CYCLES(0)) u_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .WrEn(wr_b), .adr(adr_b),
        .data_in(din_b), .data_out(dout_b), .ack(ack_b), .err(err_b), .busy(busy_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem_a [int];
    logic [31:0] mem_b [int];
    logic [31:0] last_a = 32'h0;
    logic [31:0] last_b = 32'h0;

    typedef struct {
        int          sel;
        logic        wr;
        logic [31:0] adr;
        logic [31:0] data;
        logic        exp_err;
        logic [31:0] exp_q;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            req_a = r; wr_a = w; adr_a = a; din_a = d;
        end else begin
            req_b = r; wr_b = w; adr_b = a; din_b = d;
        end
    endtask

    task automatic sample(input int sel, output logic ak, output logic er,
                          output logic bz, output logic [31:0] q);
        ak = (sel == 0) ? ack_a  : ack_b;
        er = (sel == 0) ? err_a  : err_b;
        bz = (sel == 0) ? busy_a : busy_b;
        q  = (sel == 0) ? dout_a : dout_b;
    endtask

    function automatic logic has_word(input int sel, input int wi);
        return (sel == 0) ? mem_a.exists(wi) : mem_b.exists(wi);
    endfunction

    // Reference: legality by plain range arithmetic, then a word-array update.
    task automatic ref_txn(input int sel, input logic w, input logic [31:0] a,
                           input logic [31:0] d, output logic e, output logic [31:0] q);
        longint words = (sel == 0) ? 1024 : 4096;
        int     wi    = int'(a / 4);
        e = (a % 4 != 0) || (longint'(a) >= words * 4);
        if (e) begin
            q = 32'h0;
        end else if (w) begin
            if (sel == 0) mem_a[wi] = d; else mem_b[wi] = d;
            q = (sel == 0) ? last_a : last_b;
        end else begin
            q = (sel == 0) ? mem_a[wi] : mem_b[wi];
        end
        if (sel == 0) last_a = q; else last_b = q;
    endtask

    // Issue one request, scramble the inputs while it is in flight, then check
    // latency, busy span, err, data_out and that ack is a single-cycle pulse.
    task automatic do_and_check(input int sel, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic exp_err,
                                input logic [31:0] exp_q);
        logic        ak, er, bz;
        logic [31:0] q;
        int          lat = -1;
        int          busy_n = 0;
        int          wc = (sel == 0) ? 2 : 0;
        logic        got_err = 1'b0;
        logic [31:0] got_q = 32'h0;
        string       tag;
        tag = $sformatf("u%0d %s 0x%08h", sel, w ? "sw" : "lw", a);
        @(negedge clk);
        drive(sel, 1'b1, w, a, d);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
        for (int i = 0; i < 20; i++) begin
            sample(sel, ak, er, bz, q);
            if (bz) busy_n++;
            if (ak) begin
                lat = i; got_err = er; got_q = q;
                break;
            end
            @(posedge clk);
            #1;
            drive(sel, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
        end
        check({tag, " latency"}, 32'(lat), 32'(wc));
        check({tag, " busy cycles"}, 32'(busy_n), 32'(wc + 1));
        check({tag, " err"}, 32'(got_err), 32'(exp_err));
        check({tag, " data_out"}, got_q, exp_q);
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        sample(sel, ak, er, bz, q);
        check({tag, " ack low after pulse"}, 32'(ak), 32'h0);
        check({tag, " busy low after pulse"}, 32'(bz), 32'h0);
    endtask

    initial begin
        logic        e;
        logic [31:0] q;
        int          ack_seen;

        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("reset ack_a", 32'(ack_a), 32'h0);
        check("reset busy_a", 32'(busy_a), 32'h0);
        check("reset err_a", 32'(err_a), 32'h0);
        check("reset data_out_a", dout_a, 32'h0);
        check("reset ack_b", 32'(ack_b), 32'h0);
        check("reset data_out_b", dout_b, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // sel, wr, adr, data, exp_err, exp_data_out
        vecs.push_back('{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0});
        vecs.push_back('{0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF});
        vecs.push_back('{0, 1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'h0});
        vecs.push_back('{0, 1'b1, 32'h0000_0000, 32'h0BAD_F00D, 1'b0, 32'h0});
        vecs.push_back('{0, 1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 1'b1, 32'h0});
        vecs.push_back('{0, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0BAD_F00D});
        vecs.push_back('{0, 1'b1, 32'h0000_0FFC, 32'hA5A5_A5A5, 1'b0, 32'h0BAD_F00D});
        vecs.push_back('{0, 1'b0, 32'h0000_0FFC, 32'h0,         1'b0, 32'hA5A5_A5A5});
        vecs.push_back('{0, 1'b1, 32'h0000_3FFC, 32'h5A5A_5A5A, 1'b1, 32'h0});
        vecs.push_back('{0, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0BAD_F00D});
        vecs.push_back('{1, 1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'h0});
        vecs.push_back('{1, 1'b1, 32'h0000_3FFC, 32'hA5A5_A5A5, 1'b0, 32'h0});
        vecs.push_back('{1, 1'b0, 32'h0000_3FFC, 32'h0,         1'b0, 32'hA5A5_A5A5});
        vecs.push_back('{1, 1'b0, 32'h0000_4000, 32'h0,         1'b1, 32'h0});
        vecs.push_back('{1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0000_0001});
        foreach (vecs[i]) begin
            do_and_check(vecs[i].sel, vecs[i].wr, vecs[i].adr, vecs[i].data,
                         vecs[i].exp_err, vecs[i].exp_q);
            ref_txn(vecs[i].sel, vecs[i].wr, vecs[i].adr, vecs[i].data, e, q);
        end

        // Zero wait states with req held high: ack on every other cycle.
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 32'h0000_3FFC, 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("b2b ack cycle %0d", i), 32'(ack_b), 32'((i % 2) == 0));
            if ((i % 2) == 0) check($sformatf("b2b data cycle %0d", i), dout_b, 32'hA5A5_A5A5);
        end
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);

        // Reset in the middle of a store's wait states drops the store.
        do_and_check(0, 1'b1, 32'h0000_0020, 32'h1111_1111, 1'b0, 32'h0BAD_F00D);
        ref_txn(0, 1'b1, 32'h0000_0020, 32'h1111_1111, e, q);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid-wait reset ack", 32'(ack_a), 32'h0);
        check("mid-wait reset busy", 32'(busy_a), 32'h0);
        check("mid-wait reset err", 32'(err_a), 32'h0);
        check("mid-wait reset data_out", dout_a, 32'h0);
        ack_seen = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (ack_a) ack_seen++;
        end
        check("mid-wait reset ack count", 32'(ack_seen), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        last_a = 32'h0;
        last_b = 32'h0;
        do_and_check(0, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'h1111_1111);
        ref_txn(0, 1'b0, 32'h0000_0020, 32'h0, e, q);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 80; n++) begin
            int          sel  = int'($urandom_range(0, 1));
            int          dl2  = (sel == 0) ? 10 : 12;
            int          idx  = ($urandom_range(0, 9) == 9) ? ((1 << dl2) - 1)
                                                             : int'($urandom_range(0, 7));
            int          mode = int'($urandom_range(0, 9));
            logic        w    = 1'($urandom_range(0, 1));
            logic [31:0] d    = $urandom;
            logic [31:0] a    = 32'(idx * 4);
            if (mode == 0) a = a + 32'($urandom_range(1, 3));
            else if (mode == 1) a = ($urandom_range(0, 1) == 1) ? (a + 32'(4 << dl2))
                                                                : (a | 32'h8000_0000);
            if (!w && mode > 1 && !has_word(sel, idx)) w = 1'b1;
            ref_txn(sel, w, a, d, e, q);
            do_and_check(sel, w, a, d, e, q);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
